// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between the Ibex fetch port (m0)
// and data port (m1). It also range-checks addresses and routes each response back to its owner.
module ram_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h1000,
  parameter logic [31:0] SIZE      = 32'h1000,
  parameter int          RAM_AW    = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic              ram_rvalid,
  input  logic [31:0]       ram_rdata
);

  // Handshake: a master holds req and its fields until gnt (combinational, same cycle);
  // the response (rvalid, plus err on a window miss) arrives exactly one cycle after gnt.

  logic [31:0] w_off0;
  logic [31:0] w_off1;
  logic        w_hit0;
  logic        w_hit1;

  // Offset is taken before the range test so BASE_ADDR+SIZE never has to be formed.
  assign w_off0 = m0_addr - BASE_ADDR;
  assign w_off1 = m1_addr - BASE_ADDR;
  assign w_hit0 = (m0_addr >= BASE_ADDR) && (w_off0 < SIZE);
  assign w_hit1 = (m1_addr >= BASE_ADDR) && (w_off1 < SIZE);

  // Arbitration pointer: r_last_gnt holds the most recent winner (0 = m0, 1 = m1).
  logic r_last_gnt;
  logic w_last_gnt_nxt;
  logic w_gnt_any;
  logic w_sel;
  logic w_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_gnt <= 1'b1;
    end else begin
      r_last_gnt <= w_last_gnt_nxt;
    end
  end

  always_comb begin
    w_gnt_any      = m0_req | m1_req;
    w_sel          = (m0_req & m1_req) ? ~r_last_gnt : m1_req;
    w_last_gnt_nxt = w_gnt_any ? w_sel : r_last_gnt;
  end

  always_comb begin
    m0_gnt    = w_gnt_any & ~w_sel;
    m1_gnt    = w_gnt_any & w_sel;
    w_hit     = w_sel ? w_hit1 : w_hit0;
    ram_req   = w_gnt_any & w_hit;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ram_req) begin
      if (w_sel) begin
        ram_we    = m1_we;
        ram_be    = m1_be;
        ram_addr  = w_off1[RAM_AW+1:2];
        ram_wdata = m1_wdata;
      end else begin
        ram_we    = m0_we;
        ram_be    = m0_be;
        ram_addr  = w_off0[RAM_AW+1:2];
        ram_wdata = m0_wdata;
      end
    end
  end

  // Response record for the transaction granted in the previous cycle.
  logic r_rsp_valid;
  logic r_rsp_owner;
  logic r_rsp_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt_any;
      r_rsp_owner <= w_gnt_any & w_sel;
      r_rsp_err   <= w_gnt_any & ~w_hit;
    end
  end

  logic        w_rsp;
  logic        w_rsp_err;
  logic [31:0] w_rsp_data;

  always_comb begin
    w_rsp      = r_rsp_valid & (r_rsp_err | ram_rvalid);
    w_rsp_err  = r_rsp_valid & r_rsp_err;
    w_rsp_data = (r_rsp_valid & ~r_rsp_err & ram_rvalid) ? ram_rdata : 32'h0;
    m0_rvalid  = w_rsp & ~r_rsp_owner;
    m0_err     = w_rsp_err & ~r_rsp_owner;
    m0_rdata   = r_rsp_owner ? 32'h0 : w_rsp_data;
    m1_rvalid  = w_rsp & r_rsp_owner;
    m1_err     = w_rsp_err & r_rsp_owner;
    m1_rdata   = r_rsp_owner ? w_rsp_data : 32'h0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic, a RAM responder,
// and a scoreboard whose monitor checks every response against a reference model.
module tb_ram_port_arbiter;

  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] SIZE = 32'h1000;
  localparam int          AW   = 10;
  localparam int          W    = 50;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [3:0]    m0_be, m1_be;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          ram_req, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_rvalid, ram_rdata_dummy;
  logic [31:0]   ram_rdata;

  always #5 clk_i = ~clk_i;

  ram_port_arbiter #(.BASE_ADDR(BASE), .SIZE(SIZE), .RAM_AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];   // {due_cycle[15:0], owner, err, rdata}
  logic [31:0] ram_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        p_req [2];
  logic        p_we [2];
  logic [3:0]  p_be [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  int          ref_last = 1;
  bit          force_spur = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(SIZE));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: return BASE;
      1: return BASE + SIZE - 32'd4;
      2: return BASE - 32'd4;
      3: return BASE + SIZE;
      4: return $urandom;
      default: return BASE + 32'($urandom_range(0, 32'hFFF));
    endcase
  endfunction

  task automatic set_req(input int m, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    p_req[m] = 1'b1; p_we[m] = we; p_be[m] = be; p_addr[m] = addr; p_wdata[m] = wdata;
  endtask

  task automatic drive_inputs();
    m0_req   = p_req[0];
    m0_we    = p_req[0] ? p_we[0]    : 1'($urandom);
    m0_be    = p_req[0] ? p_be[0]    : 4'($urandom);
    m0_addr  = p_req[0] ? p_addr[0]  : $urandom;
    m0_wdata = p_req[0] ? p_wdata[0] : $urandom;
    m1_req   = p_req[1];
    m1_we    = p_req[1] ? p_we[1]    : 1'($urandom);
    m1_be    = p_req[1] ? p_be[1]    : 4'($urandom);
    m1_addr  = p_req[1] ? p_addr[1]  : $urandom;
    m1_wdata = p_req[1] ? p_wdata[1] : $urandom;
  endtask

  task automatic chk_ram_idle();
    chk("ram_idle", {ram_req, ram_we, ram_be, ram_addr, ram_wdata}, 64'h0);
  endtask

  // One bus cycle: drive pending requests, predict the grant and RAM access mid-cycle.
  task automatic step();
    int          win;
    bit          hit;
    logic [31:0] idx;
    logic [31:0] rd;
    drive_inputs();
    @(negedge clk_i);
    if (p_req[0] && p_req[1]) win = 1 - ref_last;
    else if (p_req[0])        win = 0;
    else if (p_req[1])        win = 1;
    else                      win = -1;
    chk("m0_gnt", m0_gnt, 64'(win == 0));
    chk("m1_gnt", m1_gnt, 64'(win == 1));
    if (win >= 0) begin
      hit = in_win(p_addr[win]);
      idx = (p_addr[win] - BASE) >> 2;
      chk("ram_req", ram_req, 64'(hit));
      if (hit) begin
        chk("ram_we", ram_we, p_we[win]);
        chk("ram_be", ram_be, p_be[win]);
        chk("ram_addr", ram_addr, idx[AW-1:0]);
        chk("ram_wdata", ram_wdata, p_wdata[win]);
        rd = ref_mem[idx[AW-1:0]];
        if (p_we[win]) ref_mem[idx[AW-1:0]] = merge(rd, p_wdata[win], p_be[win]);
      end else begin
        rd = 32'h0;
        chk_ram_idle();
      end
      exp_q.push_back({16'(cyc + 1), 1'(win), ~hit, rd});
      ref_last = win;
      p_req[win] = 1'b0;
    end else begin
      chk_ram_idle();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst_ni = 1'b0;
    exp_q.delete();
    ref_last = 1;
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    drive_inputs();
    repeat (ncyc) begin
      @(negedge clk_i);
      chk("rst_m0", {m0_gnt, m0_rvalid, m0_err, m0_rdata}, 64'h0);
      chk("rst_m1", {m1_gnt, m1_rvalid, m1_err, m1_rdata}, 64'h0);
      chk_ram_idle();
      @(posedge clk_i);
      #1;
    end
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    while (p_req[0] || p_req[1]) step();
    step();
  endtask

  // RAM responder: answers one cycle after ram_req, occasionally with a spurious rvalid.
  initial begin
    logic          cap, cwe;
    logic [3:0]    cbe;
    logic [AW-1:0] cad;
    logic [31:0]   cwd;
    ram_rvalid = 1'b0;
    ram_rdata  = 32'h0;
    forever begin
      @(negedge clk_i);
      cap = ram_req; cwe = ram_we; cbe = ram_be; cad = ram_addr; cwd = ram_wdata;
      @(posedge clk_i);
      #1;
      if (cap) begin
        ram_rvalid = 1'b1;
        ram_rdata  = ram_mem[cad];
        if (cwe) ram_mem[cad] = merge(ram_mem[cad], cwd, cbe);
      end else begin
        ram_rvalid = force_spur || ($urandom_range(0, 3) == 0);
        ram_rdata  = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a master sees a response.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk_i);
      if (m0_rvalid && m1_rvalid) begin
        chk("dual_rvalid", {m1_rvalid, m0_rvalid}, 64'h1);
      end else if (m0_rvalid || m1_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rvalid", {m1_rvalid, m0_rvalid}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", cyc[15:0], e[49:34]);
          chk("rsp_owner", m1_rvalid, e[33]);
          chk("rsp_err", m1_rvalid ? m1_err : m0_err, e[32]);
          chk("rsp_rdata", m1_rvalid ? m1_rdata : m0_rdata, e[31:0]);
          chk("rsp_nonowner", m1_rvalid ? {m0_err, m0_rdata} : {m1_err, m1_rdata}, 64'h0);
        end
      end else begin
        chk("idle_rsp0", {m0_err, m0_rdata}, 64'h0);
        chk("idle_rsp1", {m1_err, m1_rdata}, 64'h0);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (e[49:34] <= cyc[15:0]) begin
            chk("missing_rvalid", 64'h0, 64'h1);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[1] = 32'hDEADBEEF;
    ref_mem[1] = 32'hDEADBEEF;
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    do_reset(2);

    // Both masters request every cycle right after reset: m0 first, then alternating.
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 2; m++)
        if (!p_req[m]) set_req(m, 1'b0, 4'hF, BASE + 32'($urandom_range(0, 32'hFFF)), 32'h0);
      step();
    end
    drain();

    set_req(1, 1'b0, 4'hF, 32'h0000_1004, 32'h0);
    drain();

    set_req(0, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
    step();
    set_req(1, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0);
    drain();

    set_req(1, 1'b1, 4'b0011, 32'h0000_1FFC, 32'h1234_5678);
    step();
    set_req(0, 1'b0, 4'hF, 32'h0000_1FFC, 32'h0);
    drain();

    force_spur = 1'b1;
    repeat (3) step();
    force_spur = 1'b0;

    // Reset lands in the cycle after an m0 grant; that response must vanish.
    set_req(0, 1'b0, 4'hF, 32'h0000_1010, 32'h0);
    step();
    do_reset(2);
    set_req(0, 1'b0, 4'hF, 32'h0000_1020, 32'h0);
    set_req(1, 1'b0, 4'hF, 32'h0000_1024, 32'h0);
    drain();

    for (int k = 0; k < 400; k++) begin
      for (int m = 0; m < 2; m++)
        if (!p_req[m] && $urandom_range(0, 2) != 0)
          set_req(m, $urandom_range(0, 2) == 0, 4'($urandom), rand_addr(), $urandom);
      step();
    end
    drain();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
